// File: rtl/regfile_access_arbiter.sv
// Access sequencer for a small register file: clears every register after reset,
// then serves two requesters one operation at a time with round-robin arbitration.
//
// state   | meaning
// INIT    | clearing sweep, one register per cycle, no requests accepted
// IDLE    | waiting for a request; grant and accept in the same cycle
// ISSUE   | drive read addresses, write strobe for write ops
// CAPTURE | sample read data, pulse completion for the granted requester
module regfile_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_ra1,
  input  logic [ADDR_W-1:0] req0_ra2,
  input  logic [ADDR_W-1:0] req0_wa,
  input  logic [DATA_W-1:0] req0_wd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_ra1,
  input  logic [ADDR_W-1:0] req1_ra2,
  input  logic [ADDR_W-1:0] req1_wa,
  input  logic [DATA_W-1:0] req1_wd,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rd1,
  output logic [DATA_W-1:0] rsp_rd2,
  output logic              init_done,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, CAPTURE} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = '1;

  state_t state, nextState;

  logic [ADDR_W-1:0] initCnt;
  logic              lastGrant;
  logic              grantId;
  logic              opWe;
  logic [ADDR_W-1:0] opRa1, opRa2, opWa;
  logic [DATA_W-1:0] opWd;

  // Last values driven to the register file, held while it is not being used
  logic [ADDR_W-1:0] heldRa1, heldRa2, heldWa;
  logic [DATA_W-1:0] heldWd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = state;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    rf_write      = 1'b0;
    rf_write_reg  = heldWa;
    rf_write_data = heldWd;
    rf_read_reg1  = heldRa1;
    rf_read_reg2  = heldRa2;
    // Reset forces every output low even though state is already INIT
    if (!reset) begin
      unique case (state)
        INIT: begin
          rf_write      = 1'b1;
          rf_write_reg  = initCnt;
          rf_write_data = '0;
          if (initCnt == LAST_REG) nextState = IDLE;
        end
        IDLE: begin
          if (req0_valid && req1_valid) begin
            req0_ready = lastGrant;
            req1_ready = !lastGrant;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
          if (req0_valid || req1_valid) nextState = ISSUE;
        end
        ISSUE: begin
          rf_read_reg1 = opRa1;
          rf_read_reg2 = opRa2;
          if (opWe) begin
            rf_write      = 1'b1;
            rf_write_reg  = opWa;
            rf_write_data = opWd;
          end
          nextState = CAPTURE;
        end
        CAPTURE: begin
          rf_read_reg1 = opRa1;
          rf_read_reg2 = opRa2;
          rsp0_valid   = !grantId;
          rsp1_valid   = grantId;
          nextState    = IDLE;
        end
        default: nextState = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      initCnt   <= '0;
      init_done <= 1'b0;
      lastGrant <= 1'b1;
      grantId   <= 1'b0;
      opWe      <= 1'b0;
      opRa1     <= '0;
      opRa2     <= '0;
      opWa      <= '0;
      opWd      <= '0;
      rsp_rd1   <= '0;
      rsp_rd2   <= '0;
      heldRa1   <= '0;
      heldRa2   <= '0;
      heldWa    <= '0;
      heldWd    <= '0;
    end else begin
      heldRa1 <= rf_read_reg1;
      heldRa2 <= rf_read_reg2;
      heldWa  <= rf_write_reg;
      heldWd  <= rf_write_data;
      if (state == INIT) begin
        initCnt <= initCnt + 1'b1;
        if (initCnt == LAST_REG) init_done <= 1'b1;
      end
      if (req0_ready || req1_ready) begin
        grantId   <= req1_ready;
        lastGrant <= req1_ready;
        opWe      <= req1_ready ? req1_we  : req0_we;
        opRa1     <= req1_ready ? req1_ra1 : req0_ra1;
        opRa2     <= req1_ready ? req1_ra2 : req0_ra2;
        opWa      <= req1_ready ? req1_wa  : req0_wa;
        opWd      <= req1_ready ? req1_wd  : req0_wd;
      end
      if (state == CAPTURE && !opWe) begin
        rsp_rd1 <= rf_read_data1;
        rsp_rd2 <= rf_read_data2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: register-file model, directed vector table,
// hand-written corner sequences and randomized traffic against a transaction model.
module tb_regfile_access_arbiter;

  typedef struct packed {
    logic       we;
    logic [1:0] ra1;
    logic [1:0] ra2;
    logic [1:0] wa;
    logic [7:0] wd;
  } op_t;

  typedef struct {
    int         who;
    op_t        op;
    int         expGrant;
    logic [7:0] expRd1;
    logic [7:0] expRd2;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_we;
  logic [1:0] req0_ra1, req0_ra2, req0_wa;
  logic [7:0] req0_wd;
  logic       req1_valid, req1_ready, req1_we;
  logic [1:0] req1_ra1, req1_ra2, req1_wa;
  logic [7:0] req1_wd;
  logic       rsp0_valid, rsp1_valid, init_done;
  logic [7:0] rsp_rd1, rsp_rd2;
  logic [1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic       rf_write;
  logic [7:0] rf_write_data, rf_read_data1, rf_read_data2;

  int checks = 0;
  int errors = 0;

  regfile_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_ra1(req0_ra1), .req0_ra2(req0_ra2), .req0_wa(req0_wa), .req0_wd(req0_wd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_ra1(req1_ra1), .req1_ra2(req1_ra2), .req1_wa(req1_wa), .req1_wd(req1_wd),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .init_done(init_done),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  always #5 clk = ~clk;

  // The register file itself: synchronous write, combinational read
  logic [7:0] rfMem [4];
  always @(posedge clk) if (rf_write) rfMem[rf_write_reg] <= rf_write_data;
  assign rf_read_data1 = rfMem[rf_read_reg1];
  assign rf_read_data2 = rfMem[rf_read_reg2];

  // Transaction-level reference
  logic [7:0] mdlMem [4];
  int         mdlLast;
  logic [7:0] mdlRd1, mdlRd2;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdlMem[i] = 8'h00;
    mdlLast = 1;
    mdlRd1  = 8'h00;
    mdlRd2  = 8'h00;
  endtask

  function automatic int model_grant(input bit v0, input bit v1);
    if (v0 && v1) return (mdlLast == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_apply(input int g, input op_t op);
    if (op.we) mdlMem[op.wa] = op.wd;
    else begin
      mdlRd1 = mdlMem[op.ra1];
      mdlRd2 = mdlMem[op.ra2];
    end
    mdlLast = g;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int idx, input bit v, input op_t op);
    if (idx == 0) begin
      req0_valid = v; req0_we = op.we; req0_ra1 = op.ra1; req0_ra2 = op.ra2;
      req0_wa = op.wa; req0_wd = op.wd;
    end else begin
      req1_valid = v; req1_we = op.we; req1_ra1 = op.ra1; req1_ra2 = op.ra2;
      req1_wa = op.wa; req1_wd = op.wd;
    end
  endtask

  // Called #1 into the accept cycle; walks the ISSUE and CAPTURE cycles
  task automatic serve(input int g, input op_t op);
    chk("ready0", req0_ready, g == 0);
    chk("ready1", req1_ready, g == 1);
    if (g < 0) return;
    @(negedge clk);
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    chk("issue_we", rf_write, op.we);
    if (op.we) begin
      chk("issue_wa", rf_write_reg, op.wa);
      chk("issue_wd", rf_write_data, op.wd);
    end
    chk("issue_ra1", rf_read_reg1, op.ra1);
    chk("issue_ra2", rf_read_reg2, op.ra2);
    chk("issue_noready", req0_ready | req1_ready, 0);
    chk("issue_norsp", rsp0_valid | rsp1_valid, 0);
    @(negedge clk); #1;
    chk("cap_rsp0", rsp0_valid, g == 0);
    chk("cap_rsp1", rsp1_valid, g == 1);
    chk("cap_nowrite", rf_write, 0);
    chk("cap_noready", req0_ready | req1_ready, 0);
  endtask

  // Expects reset high on entry; releases it and follows the clearing sweep
  task automatic init_sweep();
    op_t z;
    z = '0;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b1, z);
    drive(1, 1'b1, z);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("init_write", rf_write, 1);
      chk("init_reg", rf_write_reg, k);
      chk("init_data", rf_write_data, 0);
      chk("init_done_low", init_done, 0);
      chk("init_noready", req0_ready | req1_ready, 0);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("init_done_high", init_done, 1);
    chk("post_init_write", rf_write, 0);
    chk("post_init_rd1", rsp_rd1, 0);
    model_reset();
  endtask

  vec_t vecs [7];
  op_t  pend [2];
  bit   pendV [2];

  function automatic op_t mk(input bit we, input int ra1, input int ra2, input int wa, input int wd);
    op_t o;
    o.we = we; o.ra1 = 2'(ra1); o.ra2 = 2'(ra2); o.wa = 2'(wa); o.wd = 8'(wd);
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.we  = 1'($urandom_range(1, 0));
    o.ra1 = 2'($urandom_range(3, 0));
    o.ra2 = 2'($urandom_range(3, 0));
    o.wa  = 2'($urandom_range(3, 0));
    o.wd  = 8'($urandom_range(255, 0));
    return o;
  endfunction

  initial begin
    int g, prevG;
    op_t o;

    vecs[0] = '{0, mk(1, 0, 0, 2, 8'hA5), 0, 8'h00, 8'h00};
    vecs[1] = '{0, mk(0, 2, 0, 0, 0),     0, 8'hA5, 8'h00};
    vecs[2] = '{1, mk(1, 0, 0, 3, 8'h3C), 1, 8'hA5, 8'h00};
    vecs[3] = '{0, mk(1, 0, 0, 1, 8'h11), 0, 8'hA5, 8'h00};
    vecs[4] = '{0, mk(1, 0, 0, 1, 8'h22), 0, 8'hA5, 8'h00};
    vecs[5] = '{1, mk(0, 1, 3, 0, 0),     1, 8'h22, 8'h3C};
    vecs[6] = '{0, mk(0, 3, 2, 0, 0),     0, 8'h3C, 8'hA5};

    reset = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    #1;
    chk("rst_write", rf_write, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp", rsp0_valid | rsp1_valid, 0);
    chk("rst_wreg", rf_write_reg, 0);
    @(negedge clk);
    init_sweep();

    // Directed single-requester vectors, one idle cycle between ops
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].who, 1'b1, vecs[i].op);
      #1;
      serve(vecs[i].expGrant, vecs[i].op);
      model_apply(vecs[i].expGrant, vecs[i].op);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_rd1", i), rsp_rd1, vecs[i].expRd1);
      chk($sformatf("vec%0d_rd2", i), rsp_rd2, vecs[i].expRd2);
      chk($sformatf("vec%0d_idle", i), req0_ready | req1_ready, 0);
    end

    // Both requesters always valid: grants alternate on every third cycle
    prevG = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = mk(0, i % 4, (i + 1) % 4, 0, 0);
      drive(0, 1'b1, o);
      drive(1, 1'b1, o);
      #1;
      g = model_grant(1'b1, 1'b1);
      if (i > 0) begin
        chk("alt_grant", g, 1 - prevG);
        chk("alt_rd1", rsp_rd1, mdlRd1);
        chk("alt_rd2", rsp_rd2, mdlRd2);
      end
      serve(g, o);
      model_apply(g, o);
      prevG = g;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("alt_last_rd1", rsp_rd1, mdlRd1);

    // Randomized traffic; pending ops are held until accepted or withdrawn
    pendV[0] = 1'b0;
    pendV[1] = 1'b0;
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (pendV[r] && $urandom_range(7, 0) == 0) pendV[r] = 1'b0;
        else if (!pendV[r] && $urandom_range(1, 0) == 1) begin
          pendV[r] = 1'b1;
          pend[r]  = rnd_op();
        end
        drive(r, pendV[r], pend[r]);
      end
      #1;
      chk("rnd_rd1", rsp_rd1, mdlRd1);
      chk("rnd_rd2", rsp_rd2, mdlRd2);
      g = model_grant(pendV[0], pendV[1]);
      if (g >= 0) begin
        o = pend[g];
        serve(g, o);
        model_apply(g, o);
        pendV[g] = 1'b0;
      end else begin
        serve(-1, o);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rnd_final_rd1", rsp_rd1, mdlRd1);

    // Reset in the ISSUE cycle of a write drops the op entirely
    @(negedge clk);
    drive(1, 1'b1, mk(1, 0, 0, 0, 8'h77));
    #1;
    chk("rstw_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("rstw_issue", rf_write, 1);
    reset = 1'b1;
    #1;
    chk("rstw_write_drop", rf_write, 0);
    chk("rstw_rsp", rsp0_valid | rsp1_valid, 0);
    chk("rstw_init_done", init_done, 0);
    chk("rstw_wdata", rf_write_data, 0);
    @(negedge clk); #1;
    chk("rstw_no_rsp_later", rsp0_valid | rsp1_valid, 0);
    init_sweep();
    @(negedge clk);
    o = mk(0, 0, 1, 0, 0);
    drive(0, 1'b1, o);
    #1;
    serve(0, o);
    model_apply(0, o);
    @(negedge clk); #1;
    chk("rstw_cleared_rd1", rsp_rd1, 8'h00);
    chk("rstw_cleared_rd2", rsp_rd2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Sequences all accesses to the 4x8-bit register file and shares its single write port and two read ports between two requesters (req0 = datapath control, req1 = debug/loader).
- After reset it runs an INIT sweep that writes 0 to every register, then serves requests one at a time with round-robin arbitration.
- Register-file addresses, data and write strobes are driven only by this block; read data is captured one cycle after the addresses are driven.

Parameters:
DATA_W, 8, register data width
ADDR_W, 2, register address width (2**ADDR_W registers)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  op from requester 0 accepted this cycle
req0_we  in  1  1 = write op, 0 = read op
req0_ra1  in  ADDR_W  read address 1
req0_ra2  in  ADDR_W  read address 2
req0_wa  in  ADDR_W  write address
req0_wd  in  DATA_W  write data
req1_valid, req1_ready, req1_we, req1_ra1, req1_ra2, req1_wa, req1_wd  (same as req0, for requester 1)
rsp0_valid  out  1  one-cycle completion pulse for requester 0
rsp1_valid  out  1  one-cycle completion pulse for requester 1
rsp_rd1  out  DATA_W  read data 1 of the last completed read
rsp_rd2  out  DATA_W  read data 2 of the last completed read
init_done  out  1  high once the INIT sweep has finished
rf_read_reg1  out  ADDR_W  to register file
rf_read_reg2  out  ADDR_W  to register file
rf_write  out  1  write strobe to register file
rf_write_reg  out  ADDR_W  to register file
rf_write_data  out  DATA_W  to register file
rf_read_data1  in  DATA_W  from register file
rf_read_data2  in  DATA_W  from register file

Behaviour:
- Reset (asynchronous, any state):
  - state=INIT, init counter=0, last_grant=1.
  - All outputs 0 immediately, including rf_write.
  - Any op in flight is dropped, with no rsp pulse.
- INIT state:
  - One register per cycle: rf_write=1, rf_write_reg=counter, rf_write_data=0.
  - After counter reaches 2**ADDR_W-1: go to IDLE and set init_done=1. init_done stays high until the next reset.
  - Both ready outputs stay 0 throughout INIT.
- IDLE state:
  - If any valid is high, grant one requester and assert its ready combinationally in the same cycle.
  - Latch the granted requester's payload and grant id, update last_grant, then go to ISSUE.
  - Arbitration: if both requesters are valid, grant the one that is not last_grant. Otherwise grant whichever is valid.
  - The non-granted ready stays 0. Its valid and payload must be held until it is accepted.
- ISSUE state (1 cycle):
  - Drive rf_read_reg1/2 from the latched ra1/ra2.
  - If we=1: rf_write=1, rf_write_reg=wa, rf_write_data=wd.
  - Go to CAPTURE.
- CAPTURE state (1 cycle):
  - rf_write=0 and addresses held.
  - If the op was a read: rsp_rd1/2 <= rf_read_data1/2. Write ops leave rsp_rd1/2 unchanged.
  - Pulse rspN_valid for the granted requester; this pulse coincides with the CAPTURE cycle.
  - Go to IDLE.
- Timing: accept at cycle T, rf_write at T+1, rsp at T+2, earliest next accept at T+3. Throughput is one op per 3 cycles.
- rf_write is high only in INIT and in ISSUE of a write op. It is never high for 2 consecutive cycles outside INIT.
- Outside ISSUE/CAPTURE/INIT, rf_write_reg, rf_write_data and the rf_read_reg outputs hold their last values.
- A write op and a following read of the same address return the new data.
- A request whose valid drops before acceptance is simply not served.

Test Plan:
- Reset, then release -> rf_write high 4 consecutive cycles with rf_write_reg 0,1,2,3 and data 0; init_done rises the next cycle; no ready during INIT.
- req0 write wa=2, wd=0xA5, then req0 read ra1=2, ra2=0 -> rsp0_valid on each op; the second op gives rsp_rd1=0xA5, rsp_rd2=0x00.
- req0 and req1 valid continuously (reads) -> grants alternate req0, req1, req0, req1, with ready pulses 3 cycles apart.
- req1 write wa=3, wd=0x3C while req0 idle -> req1_ready in the same cycle; rf_write exactly one cycle at T+1; rsp1_valid at T+2; rsp_rd unchanged.
- Assert reset during ISSUE of a write -> rf_write drops immediately; no rsp pulse; INIT sweep reruns after release.
- Back-to-back writes 0x11 to r1 then 0x22 to r1, then read r1 -> rsp_rd1=0x22.
